// File: rtl/tail_light_seq_pkg.sv
// Shared types and helpers for the N-lamp tail-light sequencer.
package tail_light_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SEQ    = 2'b01,
    MODE_HAZARD = 2'b10,
    MODE_BRAKE  = 2'b11
  } mode_e;

  localparam int MAX_LAMPS = 32;

  // Fill mask for a sweep phase: bits [phase:0] lit, the phase equal to num_lamps is all-off.
  function automatic logic [MAX_LAMPS-1:0] seq_decode(input int phase, input int num_lamps);
    logic [MAX_LAMPS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if (phase < num_lamps && i <= phase) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tail_light_seq_if.sv
// Control/lamp bundle between the vehicle-mode logic and the sequencer.
interface tail_light_seq_if #(parameter int NUM_LAMPS = 3);

  logic                          en;
  tail_light_seq_pkg::mode_e     mode;
  logic [NUM_LAMPS-1:0]          light;
  logic                          sweep_done;

  modport master (output en, output mode, input light, input sweep_done);
  modport slave  (input en, input mode, output light, output sweep_done);

endinterface

// File: rtl/tick_divider.sv
// Step-rate divider: one tick every DIV enabled cycles, clearable.
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt;

  assign tick = en && (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/tail_light_seq.sv
// N-lamp tail-light sequencer: progressive fill, hazard blink and brake modes.
module tail_light_seq #(
  parameter int NUM_LAMPS = 3,
  parameter int TICK_DIV  = 1
) (
  input logic             clk,
  input logic             reset_n,
  tail_light_seq_if.slave bus
);
  import tail_light_seq_pkg::*;

  localparam int PW = $clog2(NUM_LAMPS + 1);
  localparam logic [PW-1:0] PH_OFF  = PW'(NUM_LAMPS);
  localparam logic [PW-1:0] PH_LAST = PW'(NUM_LAMPS - 1);

  logic [PW-1:0]        phase, phase_nxt;
  logic                 blink, blink_nxt;
  mode_e                mode_q;
  logic                 restart, tick, step, div_en, div_clr;
  logic [NUM_LAMPS-1:0] light_q, light_nxt;
  logic                 done_q, done_nxt;

  // Any mode change restarts the pattern and swallows a coincident tick.
  assign restart = (bus.mode != mode_q);
  assign div_en  = bus.en && (bus.mode == MODE_SEQ || bus.mode == MODE_HAZARD);
  assign div_clr = restart || (bus.mode == MODE_OFF);
  assign step    = tick && !restart;

  tick_divider #(.DIV(TICK_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (div_en),
    .clr     (div_clr),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= PH_OFF;
      blink  <= 1'b0;
      mode_q <= MODE_OFF;
    end else begin
      phase  <= phase_nxt;
      blink  <= blink_nxt;
      mode_q <= bus.mode;
    end
  end

  always_comb begin
    phase_nxt = phase;
    blink_nxt = blink;
    if (restart || bus.mode == MODE_OFF) begin
      phase_nxt = PH_OFF;
      blink_nxt = 1'b0;
    end else if (step) begin
      case (bus.mode)
        MODE_SEQ:    phase_nxt = (phase == PH_OFF) ? '0 : phase + PW'(1);
        MODE_HAZARD: blink_nxt = ~blink;
        default:     ;
      endcase
    end
  end

  // Brake and off override the lamps even on a restart edge; seq/hazard only move on a step.
  always_comb begin
    light_nxt = light_q;
    done_nxt  = 1'b0;
    case (bus.mode)
      MODE_OFF:   light_nxt = '0;
      MODE_BRAKE: light_nxt = '1;
      MODE_SEQ: begin
        if (step) begin
          light_nxt = NUM_LAMPS'(seq_decode(32'(phase_nxt), NUM_LAMPS));
          done_nxt  = (phase == PH_LAST);
        end
      end
      MODE_HAZARD: begin
        if (step) light_nxt = {NUM_LAMPS{~blink}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      light_q <= '0;
      done_q  <= 1'b0;
    end else begin
      light_q <= light_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.light      = light_q;
  assign bus.sweep_done = done_q;

endmodule
